decoded_instr_queue: RTL and testbench

- Circular FIFO between the instruction decoder and the issue stage.
- Each cycle it accepts up to two decoded instructions in program order and presents one instruction per cycle to issue, in show-ahead (first-word-fall-through) style.
- It drives the decoder's ready input, which must mean "at least 2 free slots".
- A flush from the flush controller empties it in one cycle.

---
 rtl/decoded_instr_queue_if.sv | 32 +++
 rtl/decoded_instr_queue.sv | 70 +++++++
 tb/tb_decoded_instr_queue.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/decoded_instr_queue_if.sv
// Decode-to-issue queue bundle: 2-wide push side, 1-wide show-ahead pop side, flush and status.
// Latency: none, this is only a wire bundle.
// Backpressure: ready_o (>=2 free slots) goes to decode; valid_o/pop_i handshake goes to issue.
interface decoded_instr_queue_if #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush_i;
  logic              ready_o;
  logic              push1_i;
  logic [DATA_W-1:0] data1_i;
  logic              push2_i;
  logic [DATA_W-1:0] data2_i;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;
  logic              pop_i;
  logic [CNT_W-1:0]  count_o;

  // Decoder / issue / flush-controller side.
  modport master (
    output flush_i, push1_i, data1_i, push2_i, data2_i, pop_i,
    input  ready_o, valid_o, data_o, count_o
  );

  // Queue side.
  modport slave (
    input  flush_i, push1_i, data1_i, push2_i, data2_i, pop_i,
    output ready_o, valid_o, data_o, count_o
  );
endinterface

// File: rtl/decoded_instr_queue.sv
// Circular decoded-instruction queue: up to 2 in-order pushes per cycle, 1 show-ahead pop per cycle.
// Latency: a pushed entry is visible on data_o one cycle after the push; no same-cycle bypass.
// Backpressure: ready_o needs >=2 free slots in the registered count; same-cycle pops give no credit.
module decoded_instr_queue #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  decoded_instr_queue_if.slave q
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Pointer wrap relies on dropping the carry, so DEPTH has to be a power of two.
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("decoded_instr_queue: DEPTH must be a power of two and at least 4");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  tail_p1;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              ready;
  logic              acc1;
  logic              acc2;
  logic              accp;

  // Accept decisions; ready and valid come only from the registered count.
  always_comb begin
    ready      = (count <= CNT_W'(DEPTH - 2));
    acc1       = q.push1_i & ready & ~q.flush_i;
    acc2       = q.push2_i & q.push1_i & ready & ~q.flush_i;
    accp       = q.pop_i & (count != '0) & ~q.flush_i;
    tail_p1    = tail + PTR_W'(1);
    count_next = count + CNT_W'(acc1) + CNT_W'(acc2) - CNT_W'(accp);
  end

  // Pointers and occupancy; reset and flush both collapse the queue to empty.
  always_ff @(posedge clk) begin
    if (rst || q.flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accp) begin
        head <= head + PTR_W'(1);
      end
      tail  <= tail + PTR_W'(acc1) + PTR_W'(acc2);
      count <= count_next;
    end
  end

  // Payload storage: older instruction at tail, younger at tail+1 (wraps naturally).
  always_ff @(posedge clk) begin
    if (acc1) begin
      mem[tail] <= q.data1_i;
    end
    if (acc2) begin
      mem[tail_p1] <= q.data2_i;
    end
  end

  assign q.ready_o = ready;
  assign q.valid_o = (count != '0);
  assign q.data_o  = mem[head];
  assign q.count_o = count;
endmodule

// File: tb/tb_decoded_instr_queue.sv
// Bench for decoded_instr_queue: directed vector table followed by random traffic vs a queue model.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: random pushes only offered while ready_o is high; illegal pushes are only in marked rows.
module tb_decoded_instr_queue;
  localparam int DATA_W = 128;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic clk;
  logic rst;
  logic allow_illegal;

  decoded_instr_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  decoded_instr_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream protocol rules, relaxed only for rows that break them on purpose.
  always @(posedge clk) begin
    if (!rst && !allow_illegal) begin
      a_push2_alone: assert (!(bus.push2_i && !bus.push1_i))
        else $error("protocol: push2_i without push1_i");
      a_push_not_ready: assert (!((bus.push1_i || bus.push2_i) && !bus.ready_o))
        else $error("protocol: push while ready_o low");
    end
  end

  typedef struct {
    logic       r, f, p1, p2, pp, ill;
    logic [7:0] t1, t2;
    logic       ev, er;
    int         ec;
    logic [7:0] et;
  } vec_t;

  vec_t              tbl[$];
  logic [DATA_W-1:0] mq[$];
  int                n_pass;
  int                n_total;

  function automatic logic [DATA_W-1:0] mk(input logic [7:0] t);
    return {(DATA_W / 8){t}};
  endfunction

  function automatic void add(input logic r, f, p1, p2, pp, ill, input logic [7:0] t1, t2,
                              input logic ev, er, input int ec, input logic [7:0] et);
    vec_t v;
    v.r = r; v.f = f; v.p1 = p1; v.p2 = p2; v.pp = pp; v.ill = ill;
    v.t1 = t1; v.t2 = t2; v.ev = ev; v.er = er; v.ec = ec; v.et = et;
    tbl.push_back(v);
  endfunction

  function automatic void check(input string name, input logic [DATA_W-1:0] act,
                                input logic [DATA_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endfunction

  task automatic drive(input logic r, f, p1, p2, pp, input logic [DATA_W-1:0] d1, d2);
    rst         = r;
    bus.flush_i = f;
    bus.push1_i = p1;
    bus.push2_i = p2;
    bus.pop_i   = pp;
    bus.data1_i = d1;
    bus.data2_i = d2;
  endtask

  // Reference: a queue of payloads; free space judged before the edge, flush/reset empty it.
  task automatic model_step();
    bit rdy;
    rdy = (DEPTH - mq.size()) >= 2;
    if (rst || bus.flush_i) begin
      mq.delete();
    end else begin
      if (bus.pop_i && mq.size() > 0) void'(mq.pop_front());
      if (rdy && bus.push1_i) begin
        mq.push_back(bus.data1_i);
        if (bus.push2_i) mq.push_back(bus.data2_i);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    allow_illegal = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    //   r  f  p1 p2 pp ill  t1     t2     ev er ec et
    // reset, then idle 5 cycles
    add(1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00);
    // push2 alone is ignored
    add(0, 0, 0, 1, 0, 1, 8'h04, 8'h05, 0, 1, 0, 8'h00);
    // dual push A,B then two pops
    add(0, 0, 1, 1, 0, 0, 8'h0A, 8'h0B, 1, 1, 2, 8'h0A);
    add(0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 1, 1, 8'h0B);
    add(0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00);
    // four dual pushes fill the queue; ready drops at 8
    add(0, 0, 1, 1, 0, 0, 8'h11, 8'h12, 1, 1, 2, 8'h11);
    add(0, 0, 1, 1, 0, 0, 8'h13, 8'h14, 1, 1, 4, 8'h11);
    add(0, 0, 1, 1, 0, 0, 8'h15, 8'h16, 1, 1, 6, 8'h11);
    add(0, 0, 1, 1, 0, 0, 8'h17, 8'h18, 1, 0, 8, 8'h11);
    // push while full is dropped; push + pop at 8 and at 7 only pops
    add(0, 0, 1, 1, 0, 1, 8'h21, 8'h22, 1, 0, 8, 8'h11);
    add(0, 0, 1, 1, 1, 1, 8'h23, 8'h24, 1, 0, 7, 8'h12);
    add(0, 0, 1, 0, 1, 1, 8'h25, 8'h00, 1, 1, 6, 8'h13);
    add(0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00);
    // wrap: fill 6, pop 6, then X,Y at tail 6..7 and Z,W at 0..1
    add(0, 0, 1, 1, 0, 0, 8'h31, 8'h32, 1, 1, 2, 8'h31);
    add(0, 0, 1, 1, 0, 0, 8'h33, 8'h34, 1, 1, 4, 8'h31);
    add(0, 0, 1, 1, 0, 0, 8'h35, 8'h36, 1, 1, 6, 8'h31);
    add(0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 1, 5, 8'h32);
    add(0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 1, 4, 8'h33);
    add(0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 1, 3, 8'h34);
    add(0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 1, 2, 8'h35);
    add(0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 1, 1, 8'h36);
    add(0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00);
    add(0, 0, 1, 1, 0, 0, 8'h41, 8'h42, 1, 1, 2, 8'h41);
    add(0, 0, 1, 1, 0, 0, 8'h43, 8'h44, 1, 1, 4, 8'h41);
    add(0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 1, 3, 8'h42);
    add(0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 1, 2, 8'h43);
    add(0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 1, 1, 8'h44);
    add(0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00);
    // same-cycle dual push + pop at 3, then push1 + pop at 1
    add(0, 0, 1, 1, 0, 0, 8'h51, 8'h52, 1, 1, 2, 8'h51);
    add(0, 0, 1, 0, 0, 0, 8'h53, 8'h00, 1, 1, 3, 8'h51);
    add(0, 0, 1, 1, 1, 0, 8'h54, 8'h55, 1, 1, 4, 8'h52);
    add(0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 1, 3, 8'h53);
    add(0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 1, 2, 8'h54);
    add(0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 1, 1, 8'h55);
    add(0, 0, 1, 0, 1, 0, 8'h56, 8'h00, 1, 1, 1, 8'h56);
    // flush at count 5 with push1/push2/pop high
    add(0, 0, 1, 1, 0, 0, 8'h61, 8'h62, 1, 1, 3, 8'h56);
    add(0, 0, 1, 1, 0, 0, 8'h63, 8'h64, 1, 1, 5, 8'h56);
    add(0, 1, 1, 1, 1, 0, 8'h71, 8'h72, 0, 1, 0, 8'h00);
    // reset mid-stream after 3 pushes, then reset together with flush
    add(0, 0, 1, 1, 0, 0, 8'h81, 8'h82, 1, 1, 2, 8'h81);
    add(0, 0, 1, 1, 0, 0, 8'h83, 8'h84, 1, 1, 4, 8'h81);
    add(0, 0, 1, 0, 0, 0, 8'h85, 8'h00, 1, 1, 5, 8'h81);
    add(1, 0, 1, 1, 1, 0, 8'h86, 8'h87, 0, 1, 0, 8'h00);
    add(0, 0, 1, 1, 0, 0, 8'h91, 8'h92, 1, 1, 2, 8'h91);
    add(1, 1, 1, 1, 1, 0, 8'h93, 8'h94, 0, 1, 0, 8'h00);
    add(0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      allow_illegal = tbl[i].ill;
      drive(tbl[i].r, tbl[i].f, tbl[i].p1, tbl[i].p2, tbl[i].pp, mk(tbl[i].t1), mk(tbl[i].t2));
      tick();
      check($sformatf("vec%0d valid", i), DATA_W'(bus.valid_o), DATA_W'(tbl[i].ev));
      check($sformatf("vec%0d ready", i), DATA_W'(bus.ready_o), DATA_W'(tbl[i].er));
      check($sformatf("vec%0d count", i), DATA_W'(bus.count_o), DATA_W'(tbl[i].ec));
      if (tbl[i].ev) check($sformatf("vec%0d data", i), bus.data_o, mk(tbl[i].et));
    end
    allow_illegal = 1'b0;

    // Random traffic against the queue model.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    tick();
    for (int c = 0; c < 600; c++) begin
      logic r, f, p1, p2, pp;
      r  = ($urandom_range(0, 79) == 0);
      f  = ($urandom_range(0, 39) == 0);
      p1 = bus.ready_o && ($urandom_range(0, 2) != 0);
      p2 = p1 && ($urandom_range(0, 1) != 0);
      pp = ($urandom_range(0, 3) != 0);
      drive(r, f, p1, p2, pp,
            {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom});
      tick();
      check("rnd valid", DATA_W'(bus.valid_o), DATA_W'(mq.size() != 0));
      check("rnd ready", DATA_W'(bus.ready_o), DATA_W'((DEPTH - mq.size()) >= 2));
      check("rnd count", DATA_W'(bus.count_o), DATA_W'(mq.size()));
      if (mq.size() != 0) check("rnd data", bus.data_o, mq[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
